dm_bus_arbiter: RTL
===================

// Module: dm_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the debug module's single bus slave port between NUM_HART hart-side masters.
//  Each hart uses it for debug-ROM fetches, dm_request polling and halt/resume notifications.
//  Sits between the per-hart debug bus masters and the dm bus port.
//  Registers the granted request, presents it to the dm, and returns ready/rdata to the winning hart only.
// PARAMETERS
//  NUM_HART  2  number of requesting harts (>=1); HART_W = max(1,$clog2(NUM_HART)) index width
// PORTS
//  clk         in   1            clock; all state on posedge
//  reset       in   1            synchronous, active-high reset
//  hart_valid  in   NUM_HART     per-hart request valid
//  hart_write  in   NUM_HART     per-hart write enable
//  hart_addr   in   NUM_HART*18  per-hart word address [19:2], hart i at [18*i+:18]
//  hart_wdata  in   NUM_HART*32  per-hart write data, hart i at [32*i+:32]
//  hart_ready  out  NUM_HART     one-cycle completion pulse to the granted hart
//  hart_rdata  out  32           read data, broadcast; valid only with hart_ready[i]
//  dm_valid    out  1            request valid to dm bus_valid
//  dm_ready    in   1            dm bus_ready
//  dm_write    out  1            to dm bus_write
//  dm_addr     out  18           to dm bus_addr[19:2]
//  dm_wdata    out  32           to dm bus_wdata
//  dm_rdata    in   32           dm bus_rdata
//  busy        out  1            1 while a transaction is outstanding
//  grant_id    out  HART_W       index of current/last granted hart
// BEHAVIOUR
//  Reset values: dm_valid, dm_write, dm_addr, dm_wdata, hart_ready, busy = 0; grant_id = 0.
//  Reset values: state = IDLE; last_grant = NUM_HART-1, so hart 0 wins first.
//  Bus protocol (both sides): master holds valid/addr/write/wdata until valid&&ready; that cycle is the transfer.
//  Bus protocol: rdata is valid in the transfer cycle. dm raises ready one cycle after valid and drops it after transfer.
//  FSM IDLE: if |hart_valid, pick winner = first valid index after last_grant (wrapping modulo NUM_HART).
//  FSM IDLE: register winner's addr/write/wdata onto dm_*, set dm_valid=1, grant_id=winner, busy=1 -> BUSY.
//  FSM BUSY: dm_* held stable. On dm_ready (transfer): dm_valid<=0, last_grant<=grant_id, busy<=0 -> IDLE.
//  FSM BUSY transfer cycle: hart_ready[grant_id]=1 (combinational) and hart_rdata=dm_rdata, only if hart_valid[grant_id] still high.
//  Latency: request seen in cycle N -> dm_valid in N+1 -> dm_ready and hart_ready in N+2 -> next grant decision in N+3.
//  At least one IDLE cycle between transactions: dm_ready is guaranteed low before the next dm_valid.
//  Abandon: hart drops valid while BUSY -> dm_valid stays asserted until dm_ready.
//  Abandon: the dm transaction is never cut short, since a dangling dm ready would complete the next request with stale rdata.
//  Abandon: the response is discarded, no hart_ready pulse, and rotation advances as normal.
//  Write-then-read to the same hart: each is a separate arbitration; no merging, no reordering.
//  Non-granted harts: hart_ready=0; their requests wait, and they must hold valid to keep their place.
//  hart_rdata outside a transfer = dm_rdata passthrough (don't-care); hart_ready is the only qualifier.
//  NUM_HART=1: rotation degenerates to always grant 0; timing is identical.
//  Reset mid-BUSY: next cycle all outputs are at reset values. dm shares this reset (resetn = ~reset), so no stale dm ready survives.
// STRUCTURE
//  dm_header.v: DMARB_IDLE/DMARB_BUSY state encodings and the HART_W width macro.
//  dm_header.v: the existing BUS_ADDR_* constants are reused by the bench.
//  Sub-module dm_rr_pick: combinational round-robin picker.
//  dm_rr_pick ports: req[NUM_HART], last[HART_W] -> any, idx[HART_W]; uses a double-width mask-and-priority scheme.
//  Top level holds the FSM, the registered request and the response steering.
// TESTING
//  1. hart0 read addr 0x000 after reset -> dm_valid cycle+1 with dm_addr=0, write=0.
//     -> hart_ready[0] pulses cycle+2 with hart_rdata = ROM word 0.
//  2. hart0 and hart1 request the same cycle -> hart0 granted first, then hart1 after one IDLE cycle.
//     -> hart_ready[1] never overlaps hart_ready[0].
//  3. Both harts hold valid continuously for 6 transactions -> grant_id sequence 0,1,0,1,0,1.
//  4. hart1 granted, drops valid in the first BUSY cycle -> dm_valid held until dm_ready.
//     -> no hart_ready[1] pulse; next grant goes to hart0 if requesting.
//  5. hart1 writes BUS_ADDR_CORE_HALT with wdata=1 -> dm_write=1, dm_wdata=1 -> hart_ready[1] pulse; dm reports hart 1 halted.
//  6. reset asserted in the BUSY cycle -> next cycle dm_valid=0, busy=0, hart_ready=0.
//     -> first post-reset request grants hart 0.

Source files
------------

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared types and constants for the debug-module bus arbiter.
// Holds the arbiter state encoding, bus widths and dm register addresses.
package dm_bus_arbiter_pkg;

    typedef enum logic {
        DMARB_IDLE = 1'b0,
        DMARB_BUSY = 1'b1
    } dmarb_state_e;

    localparam int BUS_AW = 18;
    localparam int BUS_DW = 32;

    // Word addresses (bits [19:2]) of dm bus locations.
    localparam logic [BUS_AW-1:0] BUS_ADDR_ROM_BASE    = 18'h00000;
    localparam logic [BUS_AW-1:0] BUS_ADDR_CORE_HALT   = 18'h00100;
    localparam logic [BUS_AW-1:0] BUS_ADDR_CORE_RESUME = 18'h00101;
    localparam logic [BUS_AW-1:0] BUS_ADDR_DM_REQUEST  = 18'h00102;

    // Hart index width; never narrower than one bit.
    function automatic int hart_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
// Ports: req (per-hart request), last (previous winner) -> any, idx (winner).
module dm_rr_pick
    import dm_bus_arbiter_pkg::*;
#(
    parameter int NUM_HART = 2,
    parameter int HART_W   = hart_w(NUM_HART)
) (
    input  logic [NUM_HART-1:0] req,
    input  logic [HART_W-1:0]   last,
    output logic                any,
    output logic [HART_W-1:0]   idx
);

    // Doubling the request vector turns the wrap into a plain priority
    // search: masking everything at or below `last` leaves the harts after
    // `last` in the low copy, followed by all harts again in the high copy.
    logic [2*NUM_HART-1:0] dbl;
    logic [2*NUM_HART-1:0] mask;
    logic [2*NUM_HART-1:0] hit;

    always_comb begin
        dbl = {req, req};
        mask = '0;
        for (int i = 0; i < 2*NUM_HART; i++) begin
            mask[i] = (i > int'(last));
        end
        hit = dbl & mask;
        any = |req;
        idx = '0;
        // Descending scan so the lowest set bit is written last and wins.
        for (int i = 2*NUM_HART-1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = HART_W'(i % NUM_HART);
            end
        end
    end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing the dm bus slave port between hart masters.
// Ports: clk/reset; hart_* request/response per hart; dm_* bus to the dm;
//   busy (transaction outstanding); grant_id (current/last granted hart).
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int NUM_HART = 2,
    parameter int HART_W   = hart_w(NUM_HART)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_HART-1:0]    hart_valid,
    input  logic [NUM_HART-1:0]    hart_write,
    input  logic [NUM_HART*18-1:0] hart_addr,
    input  logic [NUM_HART*32-1:0] hart_wdata,
    output logic [NUM_HART-1:0]    hart_ready,
    output logic [31:0]            hart_rdata,
    output logic                   dm_valid,
    input  logic                   dm_ready,
    output logic                   dm_write,
    output logic [17:0]            dm_addr,
    output logic [31:0]            dm_wdata,
    input  logic [31:0]            dm_rdata,
    output logic                   busy,
    output logic [HART_W-1:0]      grant_id
);

    localparam logic [HART_W-1:0] LAST_RST = HART_W'(NUM_HART - 1);

    dmarb_state_e      state;
    dmarb_state_e      state_n;
    logic [HART_W-1:0] last_grant;
    logic [HART_W-1:0] last_grant_n;
    logic [HART_W-1:0] grant_n;
    logic              dm_valid_n;
    logic              dm_write_n;
    logic [17:0]       dm_addr_n;
    logic [31:0]       dm_wdata_n;

    logic              pick_any;
    logic [HART_W-1:0] pick_idx;
    logic              xfer;

    logic [17:0] addr_a  [NUM_HART];
    logic [31:0] wdata_a [NUM_HART];

    for (genvar i = 0; i < NUM_HART; i++) begin : g_unpack
        assign addr_a[i]  = hart_addr[18*i +: 18];
        assign wdata_a[i] = hart_wdata[32*i +: 32];
    end

    dm_rr_pick #(
        .NUM_HART (NUM_HART),
        .HART_W   (HART_W)
    ) u_pick (
        .req  (hart_valid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign xfer       = (state == DMARB_BUSY) && dm_ready;
    assign busy       = (state == DMARB_BUSY);
    assign hart_rdata = dm_rdata;

    // A hart that abandoned its request gets no pulse; the dm side
    // still completes so no ready is left dangling.
    always_comb begin
        hart_ready = '0;
        if (xfer && hart_valid[grant_id]) begin
            hart_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant_id;
        dm_valid_n   = dm_valid;
        dm_write_n   = dm_write;
        dm_addr_n    = dm_addr;
        dm_wdata_n   = dm_wdata;
        unique case (state)
            DMARB_IDLE: begin
                if (pick_any) begin
                    grant_n    = pick_idx;
                    dm_valid_n = 1'b1;
                    dm_write_n = hart_write[pick_idx];
                    dm_addr_n  = addr_a[pick_idx];
                    dm_wdata_n = wdata_a[pick_idx];
                    state_n    = DMARB_BUSY;
                end
            end
            DMARB_BUSY: begin
                if (dm_ready) begin
                    dm_valid_n   = 1'b0;
                    last_grant_n = grant_id;
                    state_n      = DMARB_IDLE;
                end
            end
            default: state_n = DMARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DMARB_IDLE;
            last_grant <= LAST_RST;
            grant_id   <= '0;
            dm_valid   <= 1'b0;
            dm_write   <= 1'b0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            grant_id   <= grant_n;
            dm_valid   <= dm_valid_n;
            dm_write   <= dm_write_n;
            dm_addr    <= dm_addr_n;
            dm_wdata   <= dm_wdata_n;
        end
    end

endmodule
